control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  synchronous, active-high; sampled on rising edge of Clock.
REQ-003 Stop  input  1  request halt after the current instruction completes.
REQ-004 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-005 PCout, MDRout, Zlowout, Zhighout, Rout  output  1 each  bus-drive enables.
REQ-006 PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin, Rin  output  1 each  register load enables.
REQ-007 IncPC, Read  output  1 each  PC increment and memory read strobes.
REQ-008 Gra, Grb, Grc  output  1 each  selects the Ra/Rb/Rc field for the external select-encode logic.
REQ-009 operation  output  5  ALU opcode; equals IR[31:27] in ALU cycles, 5'b00000 otherwise.
REQ-010 Run  output  1  high while the sequencer is executing; low in RESET_S and HALT.
REQ-011 retired  output  16  count of completed instructions.

Function
REQ-012 States: RESET_S, T0..T6, HALT; one state per clock; Moore outputs decoded from state plus IR[31:27]; each output is 0 in any cycle where it is not listed below.
REQ-013 RESET_S: all outputs 0; next state T0.
REQ-014 T0: PCout, MARin, IncPC, PCin; next state T1.
REQ-015 T1: Read, MDRin; next state T2 (memory returns data in one cycle).
REQ-016 T2: MDRout, IRin; next state T3; IR is valid from T3 onward.
REQ-017 Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 01001, shl 01011, div 01111, mul 10000, neg 10001, not 10010, nop 11010, halt 11011; all others are treated as nop.
REQ-018 Three-register ALU ops (add, sub, and, or, shr, shl): T3 Grb+Rout+Yin; T4 Grc+Rout+Zlowin, operation=opcode; T5 Zlowout+Gra+Rin; then T0.
REQ-019 mul/div: T3 Gra+Rout+Yin; T4 Grb+Rout+Zlowin+Zhighin, operation=opcode; T5 Zlowout+LOin; T6 Zhighout+HIin; then T0.
REQ-020 neg/not: T3 Grb+Rout+Zlowin, operation=opcode; T4 Zlowout+Gra+Rin; then T0.
REQ-021 nop/unknown: from T3 with no control asserted; next state T0.
REQ-022 halt: from T3 to HALT; HALT holds all outputs 0 and Run=0 until Reset.
REQ-023 retired increments by 1 on the final cycle of every instruction (including nop and halt), and wraps 16'hFFFF -> 16'h0000.
REQ-024 Stop is sampled only in the final cycle of an instruction. If high, the next state is HALT instead of T0 (retired still increments). Stop high in any other cycle has no effect.
REQ-025 Never assert two bus-drive enables (PCout, MDRout, Zlowout, Zhighout, Rout) in the same cycle.
REQ-026 Never assert more than one of Gra/Grb/Grc in the same cycle.

Reset
REQ-027 Reset high at any rising edge, including mid-instruction or in HALT: next state RESET_S, retired=0, all outputs 0, Run=0.
REQ-028 Reset has priority over Stop and over every state transition.
REQ-029 Run is 1 in states T0..T6 only.

Verification
REQ-030 Reset 2 cycles, release, IR=0x18918000 (add R1,R2,R3) -> T0 PCout/MARin/IncPC/PCin, T1 Read/MDRin, T2 MDRout/IRin, T3 Grb/Rout/Yin, T4 Grc/Rout/Zlowin op=00011, T5 Zlowout/Gra/Rin, retired=1, back to T0.
REQ-031 IR=0x81300000 (mul R2,R6) -> T4 Zlowin+Zhighin op=10000, T5 Zlowout+LOin, T6 Zhighout+HIin, 7 cycles total, retired +1.
REQ-032 IR=0xD0000000 (nop), then IR=0xD8000000 (halt) -> nop retires at T3 in 4 cycles; halt enters HALT with Run=0, retired=2, outputs stay 0 for 10 cycles.
REQ-033 Stop pulsed in T4 of an add, low by T5 -> no effect, next T0. Stop high during T5 of an add -> HALT after T5.
REQ-034 Reset asserted in T4 of mul -> next cycle RESET_S, Zhighin=0, retired=0, then T0.
REQ-035 Preload retired=16'hFFFF via 65535 nops, one more nop -> retired=16'h0000. Across all scenarios, an assertion checks REQ-025 and REQ-026 every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired control unit for a single-bus datapath. Steps through a
//   fetch (T0..T2) and an opcode-dependent execute phase (T3..T6), one
//   state per clock, and decodes the datapath control strobes from the
//   current state and the opcode IR[31:27].
//
// Ports
//   Clock, Reset    rising-edge clock, synchronous active-high reset
//   Stop            halt request, honoured only in an instruction's last cycle
//   IR[31:0]        instruction register; only the opcode field is decoded
//   PCout..Rout     bus-drive enables (at most one per cycle)
//   PCin..Rin       register load enables
//   IncPC, Read     PC increment and memory read strobes
//   Gra/Grb/Grc     register-field selects (at most one per cycle)
//   operation[4:0]  ALU opcode in ALU cycles, zero otherwise
//   Run             high in T0..T6
//   retired[15:0]   completed-instruction count, wraps at 16 bits
module control_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        LOin,
    output logic        HIin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  operation,
    output logic        Run,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        RESET_S, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t     state;
    logic [4:0] opcode;
    logic       is_alu3;
    logic       is_muldiv;
    logic       is_unary;
    logic       is_halt;
    logic       final_step;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // Instruction class; anything not listed behaves as nop.
    always_comb begin
        is_alu3   = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01001, 5'b01011: is_alu3   = 1'b1;
            5'b01111, 5'b10000:           is_muldiv = 1'b1;
            5'b10001, 5'b10010:           is_unary  = 1'b1;
            5'b11011:                     is_halt   = 1'b1;
            default:                      ;
        endcase
    end

    // Last cycle of the current instruction. T6 is always terminal so the
    // sequencer cannot run past it even if IR changes mid-instruction.
    always_comb begin
        case (state)
            T3:      final_step = !(is_alu3 || is_muldiv || is_unary);
            T4:      final_step = is_unary;
            T5:      final_step = is_alu3;
            T6:      final_step = 1'b1;
            default: final_step = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= RESET_S;
            retired <= '0;
        end else if (final_step) begin
            retired <= retired + 16'd1;
            state   <= (is_halt || Stop) ? HALT : T0;
        end else begin
            case (state)
                RESET_S: state <= T0;
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= T4;
                T4:      state <= T5;
                T5:      state <= T6;
                T6:      state <= T0;
                HALT:    state <= HALT;
                default: state <= RESET_S;
            endcase
        end
    end

    always_comb begin
        PCout     = 1'b0;
        MDRout    = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        Rout      = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        Rin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        operation = 5'b00000;
        Run       = (state >= T0) && (state <= T6);
        case (state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                if (is_alu3) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; operation = opcode;
                end
            end
            T4: begin
                if (is_alu3) begin
                    Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; operation = opcode;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
                    operation = opcode;
                end else if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T5: begin
                if (is_alu3) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
            end
            T6: begin
                if (is_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer: a directed vector table for
//   add and mul, hand-written sequences for nop/halt, Stop and mid-instruction
//   Reset, randomized instructions checked against an instruction-level
//   reference model, the 16-bit retired wrap, and a per-cycle one-hot
//   check on the bus-drive enables and register-field selects.
module tb_control_sequencer;

    typedef logic [25:0] word_t;

    localparam word_t W_PCOUT    = word_t'(1) << 25;
    localparam word_t W_MDROUT   = word_t'(1) << 24;
    localparam word_t W_ZLOWOUT  = word_t'(1) << 23;
    localparam word_t W_ZHIGHOUT = word_t'(1) << 22;
    localparam word_t W_ROUT     = word_t'(1) << 21;
    localparam word_t W_PCIN     = word_t'(1) << 20;
    localparam word_t W_MARIN    = word_t'(1) << 19;
    localparam word_t W_MDRIN    = word_t'(1) << 18;
    localparam word_t W_IRIN     = word_t'(1) << 17;
    localparam word_t W_YIN      = word_t'(1) << 16;
    localparam word_t W_ZLOWIN   = word_t'(1) << 15;
    localparam word_t W_ZHIGHIN  = word_t'(1) << 14;
    localparam word_t W_LOIN     = word_t'(1) << 13;
    localparam word_t W_HIIN     = word_t'(1) << 12;
    localparam word_t W_RIN      = word_t'(1) << 11;
    localparam word_t W_INCPC    = word_t'(1) << 10;
    localparam word_t W_READ     = word_t'(1) << 9;
    localparam word_t W_GRA      = word_t'(1) << 8;
    localparam word_t W_GRB      = word_t'(1) << 7;
    localparam word_t W_GRC      = word_t'(1) << 6;
    localparam word_t W_RUN      = word_t'(1);

    localparam word_t FETCH0 = W_RUN | W_PCOUT | W_MARIN | W_INCPC | W_PCIN;
    localparam word_t FETCH1 = W_RUN | W_READ | W_MDRIN;
    localparam word_t FETCH2 = W_RUN | W_MDROUT | W_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_MUL  = 32'h81300000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = 32'h0;
    logic PCout, MDRout, Zlowout, Zhighout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin, Rin;
    logic IncPC, Read, Gra, Grb, Grc, Run;
    logic [4:0]  operation;
    logic [15:0] retired;
    word_t       obs;

    int passed = 0;
    int total  = 0;
    int model_ret = 0;
    word_t seq[$];

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .operation(operation), .Run(Run), .retired(retired)
    );

    assign obs = {PCout, MDRout, Zlowout, Zhighout, Rout, PCin, MARin, MDRin,
                  IRin, Yin, Zlowin, Zhighin, LOin, HIin, Rin, IncPC, Read,
                  Gra, Grb, Grc, operation, Run};

    always #5 Clock = ~Clock;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Exclusivity of bus drivers and register-field selects, every cycle.
    always @(negedge Clock) begin
        total++;
        if ($countones({PCout, MDRout, Zlowout, Zhighout, Rout}) <= 1 &&
            $countones({Gra, Grb, Grc}) <= 1)
            passed++;
        else
            $display("FAIL exclusive_enables: drivers %b selects %b required at most one each",
                     {PCout, MDRout, Zlowout, Zhighout, Rout}, {Gra, Grb, Grc});
    end

    function automatic word_t opw(input logic [4:0] op);
        return word_t'(op) << 1;
    endfunction

    // Reference model: the full control-word sequence of one instruction.
    function automatic void build_seq(input logic [4:0] op);
        seq.delete();
        seq.push_back(FETCH0);
        seq.push_back(FETCH1);
        seq.push_back(FETCH2);
        if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b01011}) begin
            seq.push_back(W_RUN | W_GRB | W_ROUT | W_YIN);
            seq.push_back(W_RUN | W_GRC | W_ROUT | W_ZLOWIN | opw(op));
            seq.push_back(W_RUN | W_ZLOWOUT | W_GRA | W_RIN);
        end else if (op inside {5'b01111, 5'b10000}) begin
            seq.push_back(W_RUN | W_GRA | W_ROUT | W_YIN);
            seq.push_back(W_RUN | W_GRB | W_ROUT | W_ZLOWIN | W_ZHIGHIN | opw(op));
            seq.push_back(W_RUN | W_ZLOWOUT | W_LOIN);
            seq.push_back(W_RUN | W_ZHIGHOUT | W_HIIN);
        end else if (op inside {5'b10001, 5'b10010}) begin
            seq.push_back(W_RUN | W_GRB | W_ROUT | W_ZLOWIN | opw(op));
            seq.push_back(W_RUN | W_ZLOWOUT | W_GRA | W_RIN);
        end else begin
            seq.push_back(W_RUN);
        end
    endfunction

    // Runs one instruction from T0; Stop is high only in cycle stop_at.
    // Returns 1 when the sequencer is expected to be in HALT afterwards.
    task automatic run_instr(input logic [31:0] ir, input int stop_at, input string tag,
                             output bit halted);
        int n;
        build_seq(ir[31:27]);
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            IR   = ir;
            Stop = (i == stop_at);
            #1;
            check($sformatf("%s_cycle%0d", tag, i), 32'(obs), 32'(seq[i]));
            check($sformatf("%s_retired%0d", tag, i), 32'(retired), 32'(model_ret));
            @(posedge Clock); #1;
        end
        Stop = 1'b0;
        model_ret = (model_ret + 1) % 65536;
        halted = (ir[31:27] == 5'b11011) || (stop_at == n - 1);
    endtask

    task automatic check_halt(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            Stop = i[0];
            #1;
            check($sformatf("%s_outs%0d", tag, i), 32'(obs), 32'h0);
            check($sformatf("%s_retired%0d", tag, i), 32'(retired), 32'(model_ret));
            @(posedge Clock); #1;
        end
        Stop = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            check("reset_outs", 32'(obs), 32'h0);
            check("reset_retired", 32'(retired), 32'h0);
        end
        Reset = 1'b0;
        #1;
        check("reset_s_outs", 32'(obs), 32'h0);
        @(posedge Clock); #1;
        model_ret = 0;
    endtask

    typedef struct {
        logic [31:0] ir;
        word_t       exp;
        int          ret;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit   halted;
        int   n;
        int   stop_at;
        logic [31:0] ir;
        logic [4:0]  rop;

        tbl[0]  = '{IR_ADD, FETCH0, 0};
        tbl[1]  = '{IR_ADD, FETCH1, 0};
        tbl[2]  = '{IR_ADD, FETCH2, 0};
        tbl[3]  = '{IR_ADD, W_RUN | W_GRB | W_ROUT | W_YIN, 0};
        tbl[4]  = '{IR_ADD, W_RUN | W_GRC | W_ROUT | W_ZLOWIN | (word_t'(5'b00011) << 1), 0};
        tbl[5]  = '{IR_ADD, W_RUN | W_ZLOWOUT | W_GRA | W_RIN, 0};
        tbl[6]  = '{IR_MUL, FETCH0, 1};
        tbl[7]  = '{IR_MUL, FETCH1, 1};
        tbl[8]  = '{IR_MUL, FETCH2, 1};
        tbl[9]  = '{IR_MUL, W_RUN | W_GRA | W_ROUT | W_YIN, 1};
        tbl[10] = '{IR_MUL, W_RUN | W_GRB | W_ROUT | W_ZLOWIN | W_ZHIGHIN | (word_t'(5'b10000) << 1), 1};
        tbl[11] = '{IR_MUL, W_RUN | W_ZLOWOUT | W_LOIN, 1};
        tbl[12] = '{IR_MUL, W_RUN | W_ZHIGHOUT | W_HIIN, 1};

        // Directed add then mul from reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            IR = tbl[i].ir;
            #1;
            check($sformatf("table_outs%0d", i), 32'(obs), 32'(tbl[i].exp));
            check($sformatf("table_retired%0d", i), 32'(retired), 32'(tbl[i].ret));
            @(posedge Clock); #1;
        end
        check("table_after_T0", 32'(obs), 32'(FETCH0));
        check("table_after_retired", 32'(retired), 32'd2);

        // nop then halt from reset: HALT holds for 10 cycles with retired=2.
        do_reset();
        run_instr(IR_NOP, -1, "nop", halted);
        run_instr(IR_HALT, -1, "halt", halted);
        check("halt_retired", 32'(retired), 32'd2);
        check("halt_run", 32'(Run), 32'd0);
        check_halt(10, "halted");

        // Stop outside the final cycle is ignored; in the final cycle it halts.
        do_reset();
        run_instr(IR_ADD, 4, "stop_t4", halted);
        run_instr(IR_ADD, 5, "stop_t5", halted);
        check_halt(3, "stop_halt");

        // Reset in T4 of mul.
        do_reset();
        build_seq(IR_MUL[31:27]);
        IR = IR_MUL;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("midrst_cycle%0d", i), 32'(obs), 32'(seq[i]));
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        #1;
        check("midrst_t4", 32'(obs), 32'(seq[4]));
        @(posedge Clock); #1;
        check("midrst_outs", 32'(obs), 32'h0);
        check("midrst_zhighin", 32'(Zhighin), 32'd0);
        check("midrst_retired", 32'(retired), 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("midrst_T0", 32'(obs), 32'(FETCH0));
        model_ret = 0;

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       rop = 5'b00011;
                1:       rop = 5'b00100;
                2:       rop = 5'b01011;
                3:       rop = 5'b01111;
                4:       rop = 5'b10000;
                5:       rop = 5'b10001;
                6:       rop = 5'b10010;
                7:       rop = 5'b11010;
                8:       rop = ($urandom_range(0, 19) == 0) ? 5'b11011 : 5'b00110;
                default: rop = 5'($urandom);
            endcase
            ir = {rop, 27'($urandom)};
            build_seq(rop);
            n = seq.size();
            stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_instr(ir, stop_at, "rand", halted);
            if (halted) begin
                check_halt(2, "rand_halt");
                do_reset();
            end
        end

        // retired wraps from FFFF to 0000.
        do_reset();
        IR = IR_NOP;
        repeat (65535 * 4) @(posedge Clock);
        #1;
        model_ret = 65535;
        check("wrap_preload", 32'(retired), 32'h0000FFFF);
        run_instr(IR_NOP, -1, "wrap_nop", halted);
        check("wrap_retired", 32'(retired), 32'h0);
        check("wrap_T0", 32'(obs), 32'(FETCH0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
